// File: rtl/apb_pkg.sv
// Shared types and widths for the wait-state APB slave memory.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int APB_WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_mem_ws_if.sv
// APB bus bundle for one slave select; clock and reset stay outside.
interface apb_slave_mem_ws_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_slave_mem_array.sv
// Byte storage with per-entry written flags, one write port and a registered read port.
module apb_slave_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rd_unwritten
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_unwritten;

  // Contents survive reset; only the written flags are cleared.
  always_ff @(posedge PCLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_written      <= '0;
      r_rdata        <= '0;
      r_rd_unwritten <= 1'b0;
    end else begin
      if (i_we) r_written[i_waddr] <= 1'b1;
      r_rdata        <= '0;
      r_rd_unwritten <= 1'b0;
      if (i_re) begin
        if (r_written[i_raddr]) r_rdata <= r_mem[i_raddr];
        else                    r_rd_unwritten <= 1'b1;
      end
    end
  end

  assign o_rdata        = r_rdata;
  assign o_rd_unwritten = r_rd_unwritten;

endmodule

// File: rtl/apb_slave_mem_ws.sv
// APB slave memory with programmable wait states and PSLVERR on range/unwritten errors.
//   state | meaning
//   IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
//   WAIT  | access phase, counting down wait states
//   READY | PREADY high for one cycle; write commits at the closing edge
module apb_slave_mem_ws
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb_slave_mem_ws_if.slave  apb
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [31:0]     DEPTH_U   = 32'(DEPTH);
  localparam logic [APB_WCNT_W-1:0] WAIT_INIT = APB_WCNT_W'(WAIT_CYCLES);

  apb_slv_state_t        r_state;
  logic [APB_WCNT_W-1:0] r_cnt;
  logic                  r_write;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_pready;
  logic                  r_range_err;

  logic                  w_setup;
  logic                  w_to_ready;
  logic                  w_acc_write;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic                  w_acc_in_range;
  logic                  w_r_in_range;
  logic                  w_we;
  logic                  w_re;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_rd_unwritten;

  assign w_setup = apb.PSEL & ~apb.PENABLE;

  // With zero wait states the read is issued on the setup edge itself, so take the live bus values.
  assign w_acc_write    = (r_state == IDLE) ? apb.PWRITE : r_write;
  assign w_acc_addr     = (r_state == IDLE) ? apb.PADDR  : r_addr;
  assign w_acc_in_range = 32'(w_acc_addr) < DEPTH_U;
  assign w_r_in_range   = 32'(r_addr) < DEPTH_U;

  always_comb begin
    w_to_ready = 1'b0;
    case (r_state)
      IDLE:    w_to_ready = w_setup && (WAIT_CYCLES == 0);
      WAIT:    w_to_ready = apb.PSEL && apb.PENABLE && (r_cnt == APB_WCNT_W'(1));
      default: w_to_ready = 1'b0;
    endcase
  end

  assign w_re = w_to_ready & ~w_acc_write & w_acc_in_range;
  assign w_we = (r_state == READY) & apb.PSEL & r_write & w_r_in_range;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pready    <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_pready    <= w_to_ready;
      r_range_err <= w_to_ready & ~w_acc_in_range;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_write <= apb.PWRITE;
            r_addr  <= apb.PADDR;
            r_wdata <= apb.PWDATA;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (!apb.PSEL) begin
            r_state <= IDLE;
          end else if (apb.PENABLE) begin
            r_cnt <= r_cnt - APB_WCNT_W'(1);
            if (r_cnt == APB_WCNT_W'(1)) r_state <= READY;
          end
        end
        READY:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  apb_slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .i_we           (w_we),
    .i_waddr        (r_addr[IDX_W-1:0]),
    .i_wdata        (r_wdata),
    .i_re           (w_re),
    .i_raddr        (w_acc_addr[IDX_W-1:0]),
    .o_rdata        (w_rdata),
    .o_rd_unwritten (w_rd_unwritten)
  );

  assign apb.PREADY  = r_pready;
  assign apb.PRDATA  = w_rdata;
  assign apb.PSLVERR = r_range_err | w_rd_unwritten;

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Bench for apb_slave_mem_ws: four instances (wait states 1, 0, 3, 7) against an array-based memory model.
module tb_apb_slave_mem_ws;

  localparam int DEPTH = 16;
  localparam int NDUT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       m_psel    = 1'b0;
  logic       m_penable = 1'b0;
  logic       m_pwrite  = 1'b0;
  logic [7:0] m_paddr   = '0;
  logic [7:0] m_pwdata  = '0;
  int         m_sel     = 0;

  logic [NDUT-1:0] w_pready;
  logic [NDUT-1:0] w_pslverr;
  logic [7:0]      w_prdata [NDUT];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [NDUT][DEPTH];
  bit         ref_wr  [NDUT][DEPTH];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
    apb_slave_mem_ws_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    assign bus.PSEL    = m_psel && (m_sel == g);
    assign bus.PENABLE = m_penable;
    assign bus.PWRITE  = m_pwrite;
    assign bus.PADDR   = m_paddr;
    assign bus.PWDATA  = m_pwdata;
    apb_slave_mem_ws #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .apb     (bus)
    );
    assign w_pready[g]  = bus.PREADY;
    assign w_pslverr[g] = bus.PSLVERR;
    assign w_prdata[g]  = bus.PRDATA;
  end

  function automatic int wait_of(input int s);
    case (s)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    for (int s = 0; s < NDUT; s++)
      for (int i = 0; i < DEPTH; i++) ref_wr[s][i] = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    m_psel    = 1'b0;
    m_penable = 1'b0;
  endtask

  // One APB transfer on instance s; ab > 0 drops PSEL in access cycle ab.
  task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d, input int ab);
    int         n;
    bit         done;
    bit         exp_err;
    logic [7:0] exp_d;
    logic [3:0] idx;
    idx     = a[3:0];
    exp_err = (int'(a) >= DEPTH) || (!wr && !ref_wr[s][idx]);
    exp_d   = (wr || exp_err) ? 8'h00 : ref_mem[s][idx];
    @(negedge clk);
    chk("pready_low_before_setup", 32'(w_pready[s]), 32'd0);
    m_sel = s; m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = wr; m_paddr = a; m_pwdata = d;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (ab != 0 && n == ab) begin
        chk("abort_cycle_pready", 32'(w_pready[s]), 32'(n == wait_of(s) + 1));
        m_psel = 1'b0; m_penable = 1'b0;
        done = 1'b1;
      end else begin
        m_penable = 1'b1;
        if (w_pready[s] === 1'b1) done = 1'b1;
      end
    end
    if (ab != 0) begin
      @(negedge clk);
      chk("abort_pready_next", 32'(w_pready[s]), 32'd0);
    end else begin
      chk("latency", 32'(n), 32'(wait_of(s) + 1));
      chk("pslverr", 32'(w_pslverr[s]), 32'(exp_err));
      if (!wr || exp_err) chk("prdata", 32'(w_prdata[s]), 32'(exp_d));
      if (done && wr && int'(a) < DEPTH) begin
        ref_mem[s][idx] = d;
        ref_wr[s][idx]  = 1'b1;
      end
    end
  endtask

  initial begin
    int         s;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    int         ab;

    clear_flags();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_pready",  32'(w_pready[i]),  32'd0);
      chk("reset_pslverr", 32'(w_pslverr[i]), 32'd0);
      chk("reset_prdata",  32'(w_prdata[i]),  32'd0);
    end
    rst_n = 1'b1;

    xfer(0, 1'b0, 8'd5, 8'h00, 0);
    go_idle();
    xfer(0, 1'b1, 8'd3, 8'h06, 0);
    xfer(0, 1'b0, 8'd3, 8'h00, 0);
    chk("wr_rd_addr3", 32'(w_prdata[0]), 32'h06);
    xfer(0, 1'b1, 8'd22, 8'h23, 0);
    chk("oor_write_err", 32'(w_pslverr[0]), 32'd1);
    xfer(0, 1'b0, 8'd6, 8'h00, 0);
    chk("alias_unwritten", 32'(w_pslverr[0]), 32'd1);
    go_idle();

    xfer(0, 1'b1, 8'd2, 8'h09, 1);
    xfer(0, 1'b0, 8'd2, 8'h00, 0);
    chk("abort_no_commit", 32'(w_pslverr[0]), 32'd1);
    xfer(2, 1'b1, 8'd2, 8'h09, 2);
    xfer(2, 1'b0, 8'd2, 8'h00, 0);
    chk("abort_w3_no_commit", 32'(w_pslverr[2]), 32'd1);
    xfer(1, 1'b1, 8'd2, 8'h09, 1);
    xfer(1, 1'b0, 8'd2, 8'h00, 0);
    chk("abort_ready_no_commit", 32'(w_pslverr[1]), 32'd1);
    go_idle();

    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 8'(i), 8'(2 * i), 0);
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 8'(i), 8'h00, 0);

    xfer(0, 1'b0, 8'd3, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pready",  32'(w_pready[0]),  32'd0);
    chk("async_rst_pslverr", 32'(w_pslverr[0]), 32'd0);
    chk("async_rst_prdata",  32'(w_prdata[0]),  32'd0);
    clear_flags();
    @(negedge clk);
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 8'd0, 8'h00, 0);
    chk("post_rst_unwritten", 32'(w_pslverr[0]), 32'd1);
    go_idle();

    for (int k = 1; k < NDUT; k++) begin
      xfer(k, 1'b0, 8'd5, 8'h00, 0);
      xfer(k, 1'b1, 8'd4, 8'(8'hA0 + k), 0);
      xfer(k, 1'b0, 8'd4, 8'h00, 0);
      go_idle();
    end

    for (int it = 0; it < 80; it++) begin
      s  = int'($urandom_range(0, NDUT - 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 19));
      d  = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, wait_of(s) + 1)) : 0;
      xfer(s, wr, a, d, ab);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
